// File: rtl/z_result_sequencer.sv
// Result sequencer: captures a 64-bit ALU result and delivers it to the bus
// as one 32-bit beat (narrow ops) or two beats with LO/HI strobes (MUL/DIV).
module z_result_sequencer #(
    parameter logic [4:0] MUL_OP = 5'b00110,
    parameter logic [4:0] DIV_OP = 5'b00111
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [63:0] alu_result,
    input  logic [4:0]  opcode,
    input  logic        z_in,
    output logic        z_busy,
    output logic [31:0] bus_out,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_hi,
    output logic        lo_we,
    output logic        hi_we,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_zreg;
    logic        r_wide;
    logic        w_capture;
    logic        w_is_wide_op;

    assign w_capture    = (r_state == IDLE) && z_in;
    assign w_is_wide_op = (opcode == MUL_OP) || (opcode == DIV_OP);

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= IDLE;
            r_zreg  <= 64'd0;
            r_wide  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_zreg <= alu_result;
                r_wide <= w_is_wide_op;
            end
        end
    end

    // Strobes are combinational on bus_ready so they coincide with the accept.
    always_comb begin
        w_state_nxt = r_state;
        z_busy      = 1'b0;
        bus_out     = 32'd0;
        bus_valid   = 1'b0;
        bus_hi      = 1'b0;
        lo_we       = 1'b0;
        hi_we       = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (z_in) begin
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                z_busy    = 1'b1;
                bus_valid = 1'b1;
                bus_out   = r_zreg[31:0];
                if (bus_ready) begin
                    if (r_wide) begin
                        lo_we       = 1'b1;
                        w_state_nxt = SEND_HI;
                    end else begin
                        done        = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            SEND_HI: begin
                z_busy    = 1'b1;
                bus_valid = 1'b1;
                bus_hi    = 1'b1;
                bus_out   = r_zreg[63:32];
                if (bus_ready) begin
                    hi_we       = 1'b1;
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_z_result_sequencer.sv
// Directed table-driven bench for z_result_sequencer plus a hand-written
// reset-abort sequence.
module tb_z_result_sequencer;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_UND = 5'b11111;

    logic        clock;
    logic        clear;
    logic [63:0] alu_result;
    logic [4:0]  opcode;
    logic        z_in;
    logic        z_busy;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_hi;
    logic        lo_we;
    logic        hi_we;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    z_result_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .alu_result (alu_result),
        .opcode     (opcode),
        .z_in       (z_in),
        .z_busy     (z_busy),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_hi     (bus_hi),
        .lo_we      (lo_we),
        .hi_we      (hi_we),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {busy, valid, hi, lo_we, hi_we, done, bus_out}
    typedef struct {
        logic        clr;
        logic        zin;
        logic [4:0]  op;
        logic [63:0] res;
        logic        rdy;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [37:0] ex(input logic b, input logic v,
                                       input logic h, input logic lw,
                                       input logic hw, input logic d,
                                       input logic [31:0] o);
        return {b, v, h, lw, hw, d, o};
    endfunction

    function automatic void add(input logic c, input logic z,
                                input logic [4:0] op, input logic [63:0] r,
                                input logic rdy, input logic [37:0] e);
        vec_t t;
        t.clr = c;
        t.zin = z;
        t.op  = op;
        t.res = r;
        t.rdy = rdy;
        t.exp = e;
        vecs.push_back(t);
    endfunction

    function automatic logic [37:0] outs();
        return {z_busy, bus_valid, bus_hi, lo_we, hi_we, done, bus_out};
    endfunction

    task automatic check(input string name, input logic [37:0] got,
                         input logic [37:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drive(input logic c, input logic z, input logic [4:0] op,
                         input logic [63:0] r, input logic rdy);
        clear      = c;
        z_in       = z;
        opcode     = op;
        alu_result = r;
        bus_ready  = rdy;
    endtask

    logic [37:0] Z;

    initial begin
        Z = '0;
        // reset / idle
        add(1, 0, OP_ADD, 64'h0, 0, Z);
        // ADD single beat
        add(1, 1, OP_ADD, 64'h7, 1, Z);
        add(1, 0, OP_ADD, 64'h0, 1, ex(1,1,0,0,0,1,32'h7));
        add(1, 0, OP_ADD, 64'h0, 0, Z);
        // MUL two beats
        add(1, 1, OP_MUL, 64'h0000_0001_FFFF_FFFE, 1, Z);
        add(1, 0, OP_MUL, 64'h0, 1, ex(1,1,0,1,0,0,32'hFFFF_FFFE));
        add(1, 0, OP_MUL, 64'h0, 1, ex(1,1,1,0,1,1,32'h0000_0001));
        add(1, 0, OP_ADD, 64'h0, 0, Z);
        // DIV with 4-cycle stall; input changes while busy are ignored
        add(1, 1, OP_DIV, 64'hAAAA_BBBB_CCCC_DDDD, 0, Z);
        add(1, 0, OP_DIV, 64'h0, 0, ex(1,1,0,0,0,0,32'hCCCC_DDDD));
        add(1, 1, OP_ADD, 64'h1111_2222_3333_4444, 0, ex(1,1,0,0,0,0,32'hCCCC_DDDD));
        add(1, 0, OP_ADD, 64'h0, 0, ex(1,1,0,0,0,0,32'hCCCC_DDDD));
        add(1, 0, OP_ADD, 64'h0, 0, ex(1,1,0,0,0,0,32'hCCCC_DDDD));
        add(1, 0, OP_ADD, 64'h0, 1, ex(1,1,0,1,0,0,32'hCCCC_DDDD));
        add(1, 0, OP_ADD, 64'h0, 0, ex(1,1,1,0,0,0,32'hAAAA_BBBB));
        add(1, 0, OP_ADD, 64'h0, 1, ex(1,1,1,0,1,1,32'hAAAA_BBBB));
        add(1, 0, OP_ADD, 64'h0, 0, Z);
        // MUL with z_in during SEND_HI, including the final accept cycle
        add(1, 1, OP_MUL, 64'h1234_5678_9ABC_DEF0, 0, Z);
        add(1, 0, OP_MUL, 64'h0, 1, ex(1,1,0,1,0,0,32'h9ABC_DEF0));
        add(1, 1, OP_ADD, 64'h5, 0, ex(1,1,1,0,0,0,32'h1234_5678));
        add(1, 1, OP_ADD, 64'h5, 1, ex(1,1,1,0,1,1,32'h1234_5678));
        add(1, 0, OP_ADD, 64'h5, 0, Z);
        // clear during SEND_HI aborts the transfer
        add(1, 1, OP_MUL, 64'h0000_00FF_0000_0011, 0, Z);
        add(1, 0, OP_MUL, 64'h0, 1, ex(1,1,0,1,0,0,32'h0000_0011));
        add(0, 1, OP_MUL, 64'h0, 0, ex(1,1,1,0,0,0,32'h0000_00FF));
        add(1, 0, OP_ADD, 64'h0, 1, Z);
        add(1, 0, OP_ADD, 64'h0, 1, Z);
        // ADD after abort
        add(1, 1, OP_ADD, 64'h2A, 1, Z);
        add(1, 0, OP_ADD, 64'h0, 1, ex(1,1,0,0,0,1,32'h0000_002A));
        add(1, 0, OP_ADD, 64'h0, 1, Z);
        // undefined opcode is narrow
        add(1, 1, OP_UND, 64'hDEAD_BEEF_0000_0042, 1, Z);
        add(1, 0, OP_ADD, 64'h0, 1, ex(1,1,0,0,0,1,32'h0000_0042));
        add(1, 0, OP_ADD, 64'h0, 1, Z);
        // clear overrides z_in in IDLE
        add(0, 1, OP_MUL, 64'h9, 1, Z);
        add(1, 0, OP_ADD, 64'h0, 1, Z);

        drive(0, 0, OP_ADD, 64'h0, 0);
        @(posedge clock);
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].zin, vecs[i].op, vecs[i].res,
                  vecs[i].rdy);
            #2;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            @(posedge clock);
            #1;
        end

        // Hand-written: clear during a stalled SEND_LO, then ready high
        drive(1, 1, OP_DIV, 64'h0000_0003_0000_0004, 0);
        #2;
        check("abort_lo_idle", outs(), Z);
        @(posedge clock);
        #1;
        drive(1, 0, OP_ADD, 64'h0, 0);
        #2;
        check("abort_lo_stall", outs(), ex(1,1,0,0,0,0,32'h4));
        @(posedge clock);
        #1;
        drive(0, 0, OP_ADD, 64'h0, 0);
        #2;
        check("abort_lo_clear", outs(), ex(1,1,0,0,0,0,32'h4));
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, OP_ADD, 64'h0, 1);
            #2;
            check($sformatf("abort_lo_after%0d", k), outs(), Z);
            @(posedge clock);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z_result_sequencer.md
Z_RESULT_SEQUENCER -- requirements
Module: z_result_sequencer

Interface
REQ-001 Parameter MUL_OP, default 5'b00110, opcode whose result is 64-bit (two beats).
REQ-002 Parameter DIV_OP, default 5'b00111, opcode whose result is 64-bit (two beats).
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 clear  input  1  reset, synchronous, active-low.
REQ-005 alu_result  input  64  ALU result word; upper half is zero for narrow ops.
REQ-006 opcode  input  5  ALU opcode accompanying alu_result.
REQ-007 z_in  input  1  capture request: latch alu_result/opcode.
REQ-008 z_busy  output  1  high while a captured result is not yet fully delivered.
REQ-009 bus_out  output  32  result beat driven to the datapath bus.
REQ-010 bus_valid  output  1  bus_out holds a valid beat.
REQ-011 bus_ready  input  1  consumer accepts the current beat.
REQ-012 bus_hi  output  1  current beat is upper word (zreg[63:32]).
REQ-013 lo_we  output  1  write strobe for LO register, 64-bit ops only.
REQ-014 hi_we  output  1  write strobe for HI register, 64-bit ops only.
REQ-015 done  output  1  one-cycle pulse on acceptance of the final beat.

Function
REQ-016 The block SHALL implement states IDLE, SEND_LO, SEND_HI, held in a registered state variable.
REQ-017 The block SHALL hold a 64-bit register zreg and a 1-bit flag wide.
REQ-018 In IDLE with z_in=1, the block SHALL load zreg<=alu_result, wide<=(opcode==MUL_OP or DIV_OP), and enter SEND_LO next cycle.
REQ-019 In IDLE with z_in=0, state, zreg and wide SHALL hold.
REQ-020 z_busy SHALL equal (state != IDLE), combinationally.
REQ-021 z_in SHALL be ignored whenever z_busy=1, including the cycle of the final beat accept; zreg SHALL not change.
REQ-022 In SEND_LO: bus_valid=1, bus_out=zreg[31:0], bus_hi=0.
REQ-023 In SEND_HI: bus_valid=1, bus_out=zreg[63:32], bus_hi=1.
REQ-024 In IDLE: bus_valid=0, bus_out=32'd0, bus_hi=0.
REQ-025 A beat SHALL be accepted exactly in a cycle with bus_valid=1 and bus_ready=1; otherwise state and bus_out SHALL hold (stall of any length).
REQ-026 SEND_LO accept with wide=1: lo_we=1 that cycle, next state SEND_HI.
REQ-027 SEND_LO accept with wide=0: done=1 that cycle, lo_we=0, hi_we=0, next state IDLE.
REQ-028 SEND_HI accept: hi_we=1 and done=1 that cycle, next state IDLE.
REQ-029 lo_we, hi_we, done SHALL be combinational from state, wide and bus_ready, and SHALL be 0 in all other cycles.
REQ-030 Latency: z_in to first bus_valid = 1 cycle; narrow transfer minimum 2 cycles z_in-to-IDLE, wide minimum 3.
REQ-031 Opcodes other than MUL_OP/DIV_OP (including undefined 13-31) SHALL be treated as narrow; alu_result is captured unmodified.
REQ-032 Changes on alu_result/opcode while busy SHALL not affect bus_out.

Reset
REQ-033 clear=0 at a rising edge SHALL force state=IDLE, zreg=64'd0, wide=0, overriding z_in and bus_ready.
REQ-034 After reset all outputs SHALL be 0: bus_out, bus_valid, bus_hi, z_busy, lo_we, hi_we, done.
REQ-035 Reset during SEND_LO/SEND_HI SHALL abort the transfer; no done, lo_we or hi_we pulse SHALL occur for it afterwards.
REQ-036 No strobe (lo_we, hi_we, done) SHALL assert in a cycle where clear=0 was sampled on the preceding edge (state IDLE).

Verification
REQ-037 ADD, alu_result=64'h0000_0000_0000_0007, z_in pulse, bus_ready=1 -> next cycle bus_out=7, bus_valid=1, done=1, lo_we=0; following cycle IDLE, z_busy=0.
REQ-038 MUL, alu_result=64'h0000_0001_FFFF_FFFE, bus_ready=1 -> beat1 bus_out=FFFF_FFFE, lo_we=1; beat2 bus_out=0000_0001, bus_hi=1, hi_we=1, done=1.
REQ-039 DIV result, bus_ready=0 for 4 cycles in SEND_LO -> bus_out stays lower word, no strobes; raise bus_ready -> transfer completes as REQ-038.
REQ-040 MUL in progress, z_in=1 with new alu_result=64'h5 during SEND_HI -> ignored; bus_out remains original upper word; after done, IDLE with zreg unchanged.
REQ-041 clear=0 during SEND_HI of a MUL -> next cycle IDLE, all outputs 0, no hi_we/done; subsequent ADD transfer works per REQ-037.
REQ-042 opcode=5'b11111 with alu_result upper word nonzero -> single beat of lower word, done=1, hi_we=lo_we=0.
